// File: rtl/lusdos_led_sequencer_if.sv
// Avalon-MM bus bundle shared by the sequencer's config slave and its PIO master.
// The same interface is instantiated with a 4-bit address on the config side and 2-bit on the PIO side.
interface lusdos_led_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lusdos_led_sequencer.sv
// LED pattern sequencer: CPU programs a pattern table and step period over the config slave,
// then the FSM replays the table into the LED PIO data register through the master port.
module lusdos_led_sequencer #(
  parameter int DEPTH = 8,
  parameter int LED_W = 8,
  parameter int PER_W = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  lusdos_led_sequencer_if.slave   cfg,
  lusdos_led_sequencer_if.master  pio,
  output logic                    busy
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0]       state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [PER_W-1:0] cnt_r, period_r, period_eff_s;
  logic             ctrl_en_r, ctrl_loop_r, done_r;
  logic [IDX_W-1:0] ctrl_len_r, len_in_s;
  logic [LED_W-1:0] pattern_r [DEPTH];
  logic             m_cs_r, busy_r;
  logic [LED_W-1:0] m_wdata_r;
  logic [31:0]      rdata_s;
  logic             cfg_wr_s, wr_ctrl_s, wr_period_s, wr_status_s, wr_pat_s, pat_sel_s;
  logic             unused_s;

  assign cfg_wr_s    = cfg.chipselect & ~cfg.write_n;
  assign pat_sel_s   = cfg.address[3] & ({1'b0, cfg.address[2:0]} < 4'(DEPTH));
  assign wr_ctrl_s   = cfg_wr_s & (cfg.address == 4'd0);
  assign wr_period_s = cfg_wr_s & (cfg.address == 4'd1);
  assign wr_status_s = cfg_wr_s & (cfg.address == 4'd2);
  assign wr_pat_s    = cfg_wr_s & pat_sel_s;
  assign unused_s    = &{1'b0, cfg.writedata[31:PER_W], pio.readdata};

  // Effective period and clamped table length derived from the programmed values.
  always_comb begin
    period_eff_s = period_r;
    len_in_s     = IDX_W'(cfg.writedata[6:4]);
    if (period_r < PER_W'(2)) begin
      period_eff_s = PER_W'(2);
    end else begin
      period_eff_s = period_r;
    end
    if (cfg.writedata[6:4] > 3'(DEPTH - 1)) begin
      len_in_s = IDX_W'(DEPTH - 1);
    end else begin
      len_in_s = IDX_W'(cfg.writedata[6:4]);
    end
  end

  // Next-state logic; a cleared EN aborts to IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_en_r) begin
          state_nxt_s = ST_WRITE;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r != PER_W'(0)) begin
          state_nxt_s = ST_WAIT;
        end else if (idx_r < ctrl_len_r) begin
          state_nxt_s = ST_WRITE;
          idx_nxt_s   = idx_r + IDX_W'(1);
        end else if (ctrl_loop_r) begin
          state_nxt_s = ST_WRITE;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_FINISH;
        end
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
    if (!ctrl_en_r) begin
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = idx_r;
    end else begin
      idx_nxt_s   = idx_nxt_s;
    end
  end

  // FSM state, step counter and registered master/busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      cnt_r     <= '0;
      m_cs_r    <= 1'b0;
      m_wdata_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (state_r == ST_WRITE) begin
        cnt_r <= period_eff_s - PER_W'(2);
      end else if ((state_r == ST_WAIT) && (cnt_r != PER_W'(0))) begin
        cnt_r <= cnt_r - PER_W'(1);
      end
      m_cs_r <= (state_nxt_s == ST_WRITE);
      if (state_nxt_s == ST_WRITE) begin
        m_wdata_r <= pattern_r[idx_nxt_s];
      end
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Config registers; a CPU write to CTRL overrides the FINISH-time EN clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_r   <= 1'b0;
      ctrl_loop_r <= 1'b0;
      ctrl_len_r  <= '0;
      period_r    <= '0;
      done_r      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pattern_r[i] <= '0;
      end
    end else begin
      if (wr_ctrl_s) begin
        ctrl_en_r   <= cfg.writedata[0];
        ctrl_loop_r <= cfg.writedata[1];
        ctrl_len_r  <= len_in_s;
      end else if (state_r == ST_FINISH) begin
        ctrl_en_r <= 1'b0;
      end
      if (wr_period_s) begin
        period_r <= cfg.writedata[PER_W-1:0];
      end
      if (wr_pat_s) begin
        pattern_r[cfg.address[IDX_W-1:0]] <= cfg.writedata[LED_W-1:0];
      end
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_WRITE)) begin
        done_r <= 1'b0;
      end else if ((state_r == ST_FINISH) && ctrl_en_r) begin
        done_r <= 1'b1;
      end else if (wr_status_s) begin
        done_r <= 1'b0;
      end
    end
  end

  // Zero-wait-state read mux; unselected or unmapped reads return 0.
  always_comb begin
    rdata_s = 32'd0;
    if (cfg.chipselect) begin
      case (cfg.address)
        4'd0: begin
          rdata_s[0]   = ctrl_en_r;
          rdata_s[1]   = ctrl_loop_r;
          rdata_s[6:4] = 3'(ctrl_len_r);
        end
        4'd1: rdata_s[PER_W-1:0] = period_r;
        4'd2: begin
          rdata_s[0]   = busy_r;
          rdata_s[6:4] = 3'(idx_r);
          rdata_s[8]   = done_r;
        end
        default: begin
          if (pat_sel_s) begin
            rdata_s = 32'(pattern_r[cfg.address[IDX_W-1:0]]);
          end else begin
            rdata_s = 32'd0;
          end
        end
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign cfg.readdata  = rdata_s;
  assign pio.address   = 2'b00;
  assign pio.chipselect = m_cs_r;
  assign pio.write_n   = ~m_cs_r;
  assign pio.writedata = {{(32-LED_W){1'b0}}, m_wdata_r};
  assign busy          = busy_r;
endmodule

// File: doc/lusdos_led_sequencer.md
# lusdos_led_sequencer

Autonomous LED pattern sequencer for the Nios II system. It holds a small pattern table and a step period, both programmed by the CPU over an Avalon-MM slave port. Once enabled, it replays the table through an Avalon-MM master port into the 8-bit LED PIO (data register, address 0) without CPU involvement. It sits between the Nios data master (config side) and the LED PIO slave (output side).

## Interface
- DEPTH, 8: pattern table entries; power of two, 2..8.
- LED_W, 8: LED data width written to the PIO.
- PER_W, 24: step-period counter width.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  4  config register address (word).
- s_chipselect  in  1  config slave select.
- s_write_n  in  1  config write strobe, active-low.
- s_writedata  in  32  config write data.
- s_readdata  out  32  config read data; combinational, zero wait states.
- m_address  out  2  PIO address; always 0.
- m_chipselect  out  1  PIO select; high only during a master write.
- m_write_n  out  1  PIO write strobe, active-low.
- m_writedata  out  32  PIO write data: {zeros, pattern[LED_W-1:0]}.
- busy  out  1  high while the sequencer is running.

## Operation
- Register map (s_address):
  - 0 CTRL: bit0 EN, bit1 LOOP, bits[6:4] LEN-1, which must be < DEPTH; larger values are clamped to DEPTH-1.
  - 1 PERIOD: bits[PER_W-1:0] = clocks between successive PIO writes; values 0 and 1 act as 2.
  - 2 STATUS (read-only): bit0 busy, bits[6:4] current index, bit8 DONE (sticky). Any write to STATUS clears DONE.
  - 8..8+DEPTH-1: pattern[i], bits[LED_W-1:0].
  - Unmapped addresses read 0; writes to them are ignored.
- Reads: s_readdata = selected register when s_chipselect is high, else 0. Unused bits read 0.
- FSM states: IDLE, WRITE, WAIT, FINISH.
  - IDLE: busy=0. Go to WRITE, with idx=0 and DONE cleared, when CTRL.EN=1 (level-sensitive).
  - WRITE: single cycle. Drives m_chipselect=1, m_write_n=0, m_writedata=pattern[idx]. Loads cnt=PERIOD_eff-2. Goes to WAIT.
  - WAIT: decrements cnt. At cnt=0:
    - if idx<LEN-1: idx++, go to WRITE;
    - else if LOOP: idx=0, go to WRITE;
    - else go to FINISH.
  - FINISH: single cycle. Clears CTRL.EN, sets DONE, goes to IDLE.
- Disable mid-run (CPU writes EN=0): at the next edge, go to IDLE from any state with no further master writes. A write in flight in that same cycle still completes. The PIO keeps the last pattern.
- PERIOD, LEN and pattern writes take effect on the next WRITE/WAIT load; the current count is not disturbed.
- CPU write to CTRL in the same cycle as FINISH clears EN: the CPU write wins, and EN=1 restarts at idx=0 from IDLE.
- The master never asserts m_chipselect outside WRITE; the PIO has no waitrequest, so each write completes in one cycle.

## Timing
- Reset values:
  - all config registers 0; idx=0, cnt=0, state IDLE;
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0.
- Config write accepted on the edge where s_chipselect=1 and s_write_n=0; effective the following cycle.
- EN written at edge N: WRITE is active during cycle N+1, and the PIO latches pattern[0] at edge N+2.
- Write-to-write spacing is exactly PERIOD_eff cycles: 1 WRITE cycle plus PERIOD_eff-1 WAIT cycles.
- Non-loop run with LEN=L: L writes. FINISH follows PERIOD_eff cycles after the last write; busy falls one cycle later.
- busy is registered and high in WRITE, WAIT and FINISH.

## Test plan
- Reset: assert reset_n=0 mid-run, with WRITE active -> all outputs are at reset values immediately; no m_chipselect pulse follows; all registers read 0.
- Single pass: patterns 0x01,0x02,0x04,0x08, LEN-1=3, PERIOD=5, EN=1 -> exactly 4 PIO writes, spaced 5 cycles, with those values; then EN=0, DONE=1, busy=0.
- Loop and wrap: LEN-1=1, LOOP=1, PERIOD=3, patterns 0xAA/0x55 -> writes 0xAA,0x55,0xAA,0x55... every 3 cycles; STATUS index alternates 0/1.
- Period clamp: PERIOD=0 and then 1 -> spacing is 2 cycles in both cases; PERIOD=2 -> also 2.
- Mid-run disable: EN=0 written during WAIT of step 2 -> no further writes; the PIO holds pattern[2]; busy=0 the next cycle; DONE stays 0.
- Collision: CPU writes EN=1 in the FINISH cycle -> EN remains 1 and the sequence restarts at pattern[0]; DONE reads 0 after the restart.
